// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and its bus-line front end.
package i2c_pkg;

    localparam int BYTE_WIDTH = 8;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_LOAD,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_slave_state_t;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: data, valid, ready.
interface axis_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA and derives single-cycle edge, START and STOP pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;
    logic [SYNC_STAGES:0]   primed;
    logic                   scl_s;
    logic                   sda_s;
    logic                   live;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            primed   <= '0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_sync[SYNC_STAGES-1];
            sda_q    <= sda_sync[SYNC_STAGES-1];
            primed   <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are suppressed until the pipeline holds real pad values, so the
    // reset preset of the flops can never fake a START after reset release.
    assign live      = primed[SYNC_STAGES];
    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign sda       = sda_s;
    assign scl_rise  = live &  scl_s & ~scl_q;
    assign scl_fall  = live & ~scl_s &  scl_q;
    assign start_det = live &  scl_s &  scl_q &  sda_q & ~sda_s;
    assign stop_det  = live &  scl_s &  scl_q & ~sda_q &  sda_s;

endmodule

// File: rtl/axis_i2c_slave.sv
// I2C target with a fixed address: write bytes go out on m_axis, read bytes come from s_axis.
module axis_i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe_o,
    axis_if.master           m_axis,
    axis_if.slave            s_axis,
    output logic             busy_o,
    output i2c_slave_state_t state
);

    // s_axis: tready is asserted combinationally only in the RD_LOAD cycle
    // and only when tvalid is already high; the transfer completes on that
    // clock edge. m_axis: tvalid, once set, holds with stable tdata until a
    // cycle where tready is high.

    logic                    sda_s;
    logic                    scl_rise;
    logic                    scl_fall;
    logic                    start_det;
    logic                    stop_det;
    logic [2:0]              bit_cnt;
    logic [BYTE_WIDTH-2:0]   shreg;
    logic [BYTE_WIDTH-1:0]   rx_byte;
    logic [BYTE_WIDTH-1:0]   tx_byte;
    logic [BYTE_WIDTH-1:0]   load_byte;
    logic [BYTE_WIDTH-1:0]   m_tdata;
    logic                    m_tvalid;
    logic                    rw;
    logic                    ack_phase;
    logic                    ack_ok;
    logic                    slot_free;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rx_byte       = {shreg, sda_s};
    assign load_byte     = s_axis.tvalid ? s_axis.tdata : IDLE_BYTE;
    assign slot_free     = !m_tvalid || m_axis.tready;
    assign s_axis.tready = (state == RD_LOAD) && s_axis.tvalid && !start_det && !stop_det;
    assign m_axis.tvalid = m_tvalid;
    assign m_axis.tdata  = m_tdata;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            tx_byte   <= '0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            ack_ok    <= 1'b0;
            sda_oe_o  <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            if (m_tvalid && m_axis.tready) m_tvalid <= 1'b0;

            if (stop_det) begin
                state     <= IDLE;
                sda_oe_o  <= 1'b0;
                busy_o    <= 1'b0;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                sda_oe_o  <= 1'b0;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
            end else begin
                case (state)
                    IDLE, WAIT_STOP: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[BYTE_WIDTH-2:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw <= sda_s;
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    state  <= ADDR_ACK;
                                    busy_o <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    // First fall ends bit 8 and starts the ACK; second fall ends the ACK.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            ack_phase <= !ack_phase;
                            if (!ack_phase) begin
                                sda_oe_o <= ~I2C_ACK;
                            end else begin
                                if (rw == I2C_READ) state <= RD_LOAD;
                                if (rw == I2C_WRITE) begin
                                    sda_oe_o <= 1'b0;
                                    state    <= WR_DATA;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[BYTE_WIDTH-2:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_ok <= slot_free;
                                if (slot_free) begin
                                    m_tdata  <= rx_byte;
                                    m_tvalid <= 1'b1;
                                end
                                state <= WR_ACK;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            ack_phase <= !ack_phase;
                            if (!ack_phase) begin
                                sda_oe_o <= ack_ok ? ~I2C_ACK : ~I2C_NACK;
                            end else begin
                                sda_oe_o <= 1'b0;
                                state    <= ack_ok ? WR_DATA : WAIT_STOP;
                            end
                        end
                    end
                    RD_LOAD: begin
                        tx_byte  <= load_byte;
                        sda_oe_o <= ~load_byte[7];
                        bit_cnt  <= '0;
                        state    <= RD_DATA;
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                sda_oe_o <= 1'b0;
                                state    <= RD_ACK;
                            end else begin
                                tx_byte  <= tx_byte << 1;
                                sda_oe_o <= ~tx_byte[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && sda_s == I2C_NACK) state <= WAIT_STOP;
                        else if (scl_fall)                 state <= RD_LOAD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/axis_i2c_slave.md
Name: axis_i2c_slave

Overview:
- I2C target (responder) to pair with the team's AXIS I2C master. Decodes SCL/SDA and matches a fixed 7-bit address.
- Master writes: each received byte is pushed out on an AXIS master port, normally into axis_fifo.
- Master reads: bytes are pulled from an AXIS slave port and shifted onto SDA.
- Fully synchronous to clk_i, with oversampled bus lines. No clock stretching.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this block responds to.
- SYNC_STAGES, 2, flip-flop synchronizer depth on scl_i/sda_i (minimum 2).
- IDLE_BYTE, 8'hFF, byte transmitted on a read when s_axis has no data.

Ports:
- clk_i  in  1  system clock; frequency must be at least 20x the SCL rate.
- arstn_i  in  1  asynchronous active-low reset.
- scl_i  in  1  raw SCL from pad.
- sda_i  in  1  raw SDA from pad.
- sda_oe_o  out  1  1 = pull SDA low (open-drain enable); 0 = release.
- m_axis  axis_if.master  8  received write bytes (tdata/tvalid/tready).
- s_axis  axis_if.slave  8  bytes to transmit on reads.
- busy_o  out  1  high from an address match to STOP.

Behaviour:
- Clock and reset: clock clk_i; reset arstn_i, asynchronous, active-low.
- Reset values: sda_oe_o=0, m_axis.tvalid=0, m_axis.tdata=0, s_axis.tready=0, busy_o=0, state=IDLE.
- Synchronization: scl_i/sda_i pass through SYNC_STAGES flops, then one history flop.
  - scl_rise / scl_fall: 1-cycle pulses from synchronized SCL.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Sampling and driving: SDA is sampled on scl_rise. sda_oe_o changes only in the cycle after scl_fall.
- Bit order: MSB first, bit counter 0..7, wraps to 0 after each ACK slot.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP.
- START (including repeated START) from any state: go to ADDR, clear bit counter, release SDA.
- STOP from any state: go to IDLE, release SDA, busy_o=0. A partial byte is discarded; m_axis contents are kept.
- ADDR: shift in 8 bits.
  - If addr[7:1]==SLAVE_ADDR: go to ADDR_ACK and set busy_o.
  - Otherwise: go to WAIT_STOP and never drive SDA.
- ADDR_ACK: drive SDA low for the 9th clock. On the following scl_fall, R/W bit selects the next state: 0 -> WR_DATA, 1 -> RD_LOAD.
- m_axis output register: single-entry. tvalid is held until tready; tdata is stable while tvalid=1.
- WR_DATA, on the 8th-bit scl_rise:
  - Output register empty, or being accepted in the same cycle: load the byte, assert tvalid, go to WR_ACK driving ACK.
  - Output register full: drop the byte, go to WR_ACK releasing SDA (NACK). Then go to WAIT_STOP.
- WR_ACK: after the ACK slot's scl_fall, return to WR_DATA.
- RD_LOAD, one cycle:
  - If s_axis.tvalid: assert s_axis.tready for exactly this cycle and latch tdata.
  - Otherwise: latch IDLE_BYTE, no pop.
  - s_axis.tready is 0 in every other cycle.
- RD_DATA: drive ~bit on sda_oe_o after each scl_fall. The first bit is driven immediately after RD_LOAD.
- RD_ACK: release SDA and sample the master's bit on scl_rise.
  - 0 (ACK): go to RD_LOAD at scl_fall.
  - 1 (NACK): go to WAIT_STOP.
- WAIT_STOP: SDA released; only START or STOP leave this state.
- Simultaneous m_axis accept and new-byte load in the same cycle: the new byte wins and tvalid stays 1.
- Reset mid-transfer: SDA released asynchronously; bus activity is ignored until the next START.

Decomposition:
- Package i2c_pkg:
  - enum i2c_slave_state_t;
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_WRITE=1'b0, I2C_READ=1'b1;
  - BYTE_WIDTH=8.
- Sub-module i2c_line_sync: synchronizer plus scl_rise, scl_fall, start_det and stop_det pulses. It is reused by the master testbench monitor.

Test Plan:
- Write, addr 0x50: bytes 0xA5, 0x3C, m_axis.tready=1 -> ACK on addr and both bytes; m_axis outputs 0xA5 then 0x3C; busy_o clears on STOP.
- Address mismatch 0x51 write plus 0x12 -> sda_oe_o stays 0 throughout; no m_axis.tvalid; busy_o stays 0.
- Read, addr 0x50: s_axis holds 0x96, 0x0F; master ACKs then NACKs -> SDA carries 10010110, 00001111; exactly two s_axis handshakes; then WAIT_STOP.
- Read with s_axis.tvalid=0 -> 0xFF transmitted; s_axis.tready never asserted.
- Backpressure: m_axis.tready=0, write 0x11, 0x22 -> 0x11 ACKed and held on tdata; 0x22 NACKed and dropped; tready=1 later yields 0x11 only.
- Repeated START write 0x01 then read, plus reset asserted mid-byte -> 0x01 pushed; read proceeds; on reset sda_oe_o=0, tvalid=0; next START decodes normally.
